// File: rtl/sram_pipe_if.sv
// Request/response bus for sram_pipe.
// Request channel : req_valid/req_ready handshake carrying write flag, byte
//                   address, write data and byte strobes.
// Response channel: rsp_valid/rsp_ready handshake carrying read data and an
//                   error flag.
// master drives requests and rsp_ready; slave (the memory) drives the rest.
interface sram_pipe_if #(
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_pipe.sv
// Single-port SRAM with pipelined read, byte-strobed write and an in-order
// response FIFO.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (memory array is not reset)
//   bus   - sram_pipe_if slave: request channel in, response channel out
// Every accepted request produces exactly one response, READ_LAT cycles
// later when the FIFO is empty. Addresses >= MEM_BYTES give rsp_err=1.
module sram_pipe #(
  parameter int MEM_BYTES = 65536,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_pipe_if.slave  bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / BYTES;
  localparam int IDX_W = AW - OFF_W;
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rd_word_q;

  logic              ready_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept, pop, addr_err;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  unused_addr_lsb;

  logic [READ_LAT-1:0]               st_v_q, st_err_q;
  logic                              st_rd_q;
  logic [READ_LAT-1:0][DATA_W-1:0]   st_data;
  logic                              fin_v, fin_err;
  logic [DATA_W-1:0]                 fin_data;

  logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_err_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic              fifo_empty, fifo_full, push, fifo_pop;
  logic              rsp_valid_w;

  assign addr_err        = |bus.req_addr[31:AW];
  assign idx             = bus.req_addr[AW-1:OFF_W];
  assign unused_addr_lsb = bus.req_addr[OFF_W-1:0];
  assign accept          = bus.req_valid && ready_q;
  assign bus.req_ready   = ready_q;

  // Array port: write and read share the accept edge; at most one per cycle.
  always_ff @(posedge clk) begin
    if (accept && !addr_err) begin
      if (bus.req_write) begin
        for (int b = 0; b < BYTES; b++)
          if (bus.req_wstrb[b]) mem_q[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end else begin
        rd_word_q <= mem_q[idx];
      end
    end
  end

  // Stage 0 holds control only; its data comes straight from the array port.
  assign st_data[0] = st_rd_q ? rd_word_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v_q   <= '0;
      st_err_q <= '0;
      st_rd_q  <= 1'b0;
    end else begin
      st_v_q[0]   <= accept;
      st_err_q[0] <= accept && addr_err;
      st_rd_q     <= accept && !addr_err && !bus.req_write;
      for (int s = 1; s < READ_LAT; s++) begin
        st_v_q[s]   <= st_v_q[s-1];
        st_err_q[s] <= st_err_q[s-1];
      end
    end
  end

  for (genvar s = 1; s < READ_LAT; s++) begin : g_stage
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= st_data[s-1];
    end
    assign st_data[s] = data_q;
  end

  assign fin_v    = st_v_q[READ_LAT-1];
  assign fin_err  = st_err_q[READ_LAT-1];
  assign fin_data = st_data[READ_LAT-1];

  // Final stage bypasses an empty FIFO; otherwise it queues behind the head.
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CW'(RSP_DEPTH));
  assign push       = fin_v && !(fifo_empty && bus.rsp_ready);
  assign fifo_pop   = !fifo_empty && bus.rsp_ready;

  assign rsp_valid_w   = !fifo_empty || fin_v;
  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_rdata = !fifo_empty ? fifo_data_q[rd_ptr_q] :
                         (fin_v ? fin_data : '0);
  assign bus.rsp_err   = !fifo_empty ? fifo_err_q[rd_ptr_q] : (fin_v && fin_err);
  assign pop           = rsp_valid_w && bus.rsp_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data_q[wr_ptr_q] <= fin_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      fifo_err_q <= '0;
    end else begin
      if (push) begin
        fifo_err_q[wr_ptr_q] <= fin_err;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Credits: one per accepted response not yet popped. Ready is registered
  // from the next count so a pop re-opens the request channel one cycle later.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d < CW'(RSP_DEPTH));
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(RSP_DEPTH));
  a_req_valid_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(bus.req_valid));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_valid && !ready_q |=> bus.req_valid && $stable(bus.req_write) &&
    $stable(bus.req_addr) && $stable(bus.req_wdata) && $stable(bus.req_wstrb));
endmodule
